// File: rtl/count_reader.sv
// count_reader: initiator side of the counter read-back interface.
// On an accepted start it sweeps idx 0..NUM_CNT-1 with a req/valid handshake per
// index, captures each returned count into a flat bus, then pulses done.
// Optional build macro COUNT_READER_SUM_EN adds a running `total` of the captured counts.
module count_reader #(
    parameter int unsigned NUM_CNT = 5,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     idle,
    input  logic                     valid,
    input  logic [CNT_W-1:0]         data,
`ifdef COUNT_READER_SUM_EN
    output logic [CNT_W+2:0]         total,
`endif
    output logic                     req,
    output logic [IDX_W-1:0]         idx,
    output logic [NUM_CNT*CNT_W-1:0] counts,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StGap, StFin} state_e;

    state_e                   state_q, state_d;
    logic                     req_q, req_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_CNT*CNT_W-1:0] counts_q, counts_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [TO_W-1:0]          tmo_q, tmo_d;

    logic accept;
    logic abort;
    logic capture;
    logic expired;
    logic last_idx;

    assign accept   = (state_q == StIdle) && start && idle;
    // Abort has priority over a coincident valid, so nothing is captured then.
    assign abort    = (state_q == StReq) && !idle;
    assign capture  = (state_q == StReq) && idle && valid;
    assign expired  = (tmo_q == TO_W'(TIMEOUT - 1));
    assign last_idx = (idx_q == IDX_W'(NUM_CNT - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StReq;
            StReq: begin
                if (abort)        state_d = StIdle;
                else if (capture) state_d = StGap;
                else if (expired) state_d = StIdle;
            end
            StGap:   state_d = last_idx ? StFin : StReq;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the timeout counter.
    always_comb begin
        req_d    = req_q;
        idx_d    = idx_q;
        counts_d = counts_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    idx_d  = '0;
                    req_d  = 1'b1;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    tmo_d  = '0;
                end
            end
            StReq: begin
                if (abort || (!capture && expired)) begin
                    err_d  = 1'b1;
                    req_d  = 1'b0;
                    busy_d = 1'b0;
                    idx_d  = '0;
                end else if (capture) begin
                    counts_d[int'(idx_q)*CNT_W +: CNT_W] = data;
                    req_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            StGap: begin
                if (last_idx) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    idx_d  = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    tmo_d = '0;
                    req_d = 1'b1;
                end
            end
            StFin:   ;
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q    <= 1'b0;
            idx_q    <= '0;
            counts_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            req_q    <= req_d;
            idx_q    <= idx_d;
            counts_q <= counts_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

`ifdef COUNT_READER_SUM_EN
    logic [CNT_W+2:0] total_q, total_d;

    // Running sum of captured counts; three guard bits keep five full-scale counts exact.
    always_comb begin
        total_d = total_q;
        if (accept) begin
            total_d = '0;
        end else if (capture) begin
            total_d = total_q + {3'b000, data};
        end
    end

    // Sum register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign total = total_q;
`endif

    assign req    = req_q;
    assign idx    = idx_q;
    assign counts = counts_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
